// File: rtl/register_scoreboard.sv
// Register scoreboard: counts outstanding writes per architectural register
// between decode issue and writeback, and raises stall on RAW hazards or full counters.
module register_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 2,
    parameter int WB_BYPASS      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      q_use_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] q_rs1,
    input  logic                      q_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] q_rs2,
    input  logic                      q_wr,
    input  logic [REG_ADDR_WIDTH-1:0] q_rd,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [6:0]                pending,
    output logic                      sb_error
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic                 BYPASS  = (WB_BYPASS != 0);

    logic [CNT_WIDTH-1:0] r_cnt [NUM_REGS];
    logic [6:0]           r_pending;
    logic                 r_sb_error;

    logic w_issue_hit;
    logic w_rel_hit;
    logic w_same_reg;
    logic w_issue_upd;
    logic w_rel_upd;
    logic w_rel_err;
    logic w_busy_rs1;
    logic w_busy_rs2;
    logic w_waw_full;
    logic [6:0] w_pending_next;

    // Issue and release of the same register cancel; saturation and empty
    // counters turn the respective event into a no-op instead of wrapping.
    always_comb begin
        w_issue_hit    = issue_valid && issue_wr && (issue_rd != '0);
        w_rel_hit      = wb_valid && (wb_rd != '0);
        w_same_reg     = w_issue_hit && w_rel_hit && (issue_rd == wb_rd);
        w_issue_upd    = w_issue_hit && !w_same_reg && (r_cnt[issue_rd] != CNT_MAX);
        w_rel_upd      = w_rel_hit && !w_same_reg && (r_cnt[wb_rd] != '0);
        w_rel_err      = w_rel_hit && (r_cnt[wb_rd] == '0);
        w_pending_next = r_pending + 7'(w_issue_upd) - 7'(w_rel_upd);
    end

    // A writeback draining the last outstanding write frees the register
    // in the same cycle when bypass is enabled.
    always_comb begin
        w_busy_rs1 = (q_rs1 != '0) && (r_cnt[q_rs1] != '0) &&
                     !(BYPASS && wb_valid && (wb_rd == q_rs1) &&
                       (r_cnt[q_rs1] == CNT_WIDTH'(1)));
        w_busy_rs2 = (q_rs2 != '0) && (r_cnt[q_rs2] != '0) &&
                     !(BYPASS && wb_valid && (wb_rd == q_rs2) &&
                       (r_cnt[q_rs2] == CNT_WIDTH'(1)));
        w_waw_full = q_wr && (q_rd != '0) && (r_cnt[q_rd] == CNT_MAX) &&
                     !(wb_valid && (wb_rd == q_rd));
        stall      = (q_use_rs1 && w_busy_rs1) || (q_use_rs2 && w_busy_rs2) || w_waw_full;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec[i] = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending  <= '0;
            r_sb_error <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            if (w_issue_upd) begin
                r_cnt[issue_rd] <= r_cnt[issue_rd] + CNT_WIDTH'(1);
            end
            if (w_rel_upd) begin
                r_cnt[wb_rd] <= r_cnt[wb_rd] - CNT_WIDTH'(1);
            end
            r_pending <= w_pending_next;
            if (w_rel_err) begin
                r_sb_error <= 1'b1;
            end
        end
    end

    assign pending  = r_pending;
    assign sb_error = r_sb_error;

endmodule

// File: tb/tb_register_scoreboard.sv
// Bench for register_scoreboard: directed hazard scenarios plus a random phase,
// checked against a behavioural per-register count model through an expected queue.
module tb_register_scoreboard;

    logic        clk;
    logic        rst;
    logic        iv, iw;
    logic [4:0]  ird;
    logic        ur1, ur2, qw;
    logic [4:0]  rs1, rs2, qrd;
    logic        wv;
    logic [4:0]  wrd;
    logic        fl;
    logic        stall;
    logic [31:0] busy_vec;
    logic [6:0]  pending;
    logic        sb_error;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt [32];
    bit m_err;

    // expected {stall, sb_error, pending[6:0], busy_vec[31:0]}
    logic [40:0] exp_q [$];

    register_scoreboard dut (
        .clk        (clk),
        .reset      (rst),
        .issue_valid(iv),
        .issue_wr   (iw),
        .issue_rd   (ird),
        .q_use_rs1  (ur1),
        .q_rs1      (rs1),
        .q_use_rs2  (ur2),
        .q_rs2      (rs2),
        .q_wr       (qw),
        .q_rd       (qrd),
        .wb_valid   (wv),
        .wb_rd      (wrd),
        .flush      (fl),
        .stall      (stall),
        .busy_vec   (busy_vec),
        .pending    (pending),
        .sb_error   (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && (m_cnt[r] != 0) && !(wv && (wrd == r) && (m_cnt[r] == 1));
    endfunction

    function automatic bit m_stall();
        return (ur1 && m_busy(rs1)) || (ur2 && m_busy(rs2)) ||
               (qw && (qrd != 0) && (m_cnt[qrd] == 3) && !(wv && (wrd == qrd)));
    endfunction

    function automatic logic [6:0] m_pending();
        int s = 0;
        for (int i = 0; i < 32; i++) s += m_cnt[i];
        return 7'(s);
    endfunction

    function automatic logic [31:0] m_busyvec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    task automatic m_clear_all();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;
    endtask

    task automatic m_update();
        bit ih, rh;
        if (rst) begin
            m_clear_all();
        end else if (fl) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            ih = iv && iw && (ird != 0);
            rh = wv && (wrd != 0);
            if (rh && m_cnt[wrd] == 0) m_err = 1'b1;
            if (!(ih && rh && ird == wrd)) begin
                if (ih && m_cnt[ird] < 3) m_cnt[ird]++;
                if (rh && m_cnt[wrd] > 0) m_cnt[wrd]--;
            end
        end
    endtask

    task automatic idle();
        iv = 0; iw = 0; ird = 0; ur1 = 0; rs1 = 0; ur2 = 0; rs2 = 0;
        qw = 0; qrd = 0; wv = 0; wrd = 0; fl = 0; rst = 0;
    endtask

    task automatic issue(input logic [4:0] r);
        iv = 1; iw = 1; ird = r;
    endtask

    // One clock: push model expectations, compare at negedge, advance model at posedge.
    task automatic tick();
        logic [40:0] e;
        exp_q.push_back({m_stall(), m_err, m_pending(), m_busyvec()});
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("sb_stall", 41'(stall), 41'(e[40]));
        check_eq("sb_error", 41'(sb_error), 41'(e[39]));
        check_eq("sb_pending", 41'(pending), 41'(e[38:32]));
        check_eq("sb_busy_vec", 41'(busy_vec), 41'(e[31:0]));
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_clear_all();
        idle();

        // 1: reset values, writes to r0 not tracked
        #1;
        check_eq("t1_reset_busy", 41'(busy_vec), 41'(0));
        check_eq("t1_reset_stall", 41'(stall), 41'(0));
        issue(5'd0); tick(); tick();
        idle(); ur1 = 1; rs1 = 0;
        #1;
        check_eq("t1_r0_pending", 41'(pending), 41'(0));
        check_eq("t1_r0_stall", 41'(stall), 41'(0));
        check_eq("t1_r0_busy", 41'(busy_vec), 41'(0));

        // 2: RAW on r2, released by bypassed writeback
        idle(); issue(5'd2); tick();
        idle(); ur1 = 1; rs1 = 2;
        #1; check_eq("t2_raw_stall", 41'(stall), 41'(1));
        tick(); tick();
        wv = 1; wrd = 2;
        #1; check_eq("t2_bypass_stall", 41'(stall), 41'(0));
        tick();
        idle();
        #1; check_eq("t2_busy2_after", 41'(busy_vec[2]), 41'(0));

        // 3: r5 counter full stalls a WAW, same-cycle writeback lifts it
        issue(5'd5); tick(); tick(); tick();
        idle(); qw = 1; qrd = 5;
        #1;
        check_eq("t3_pending3", 41'(pending), 41'(3));
        check_eq("t3_full_stall", 41'(stall), 41'(1));
        wv = 1; wrd = 5;
        #1; check_eq("t3_wb_unstall", 41'(stall), 41'(0));
        issue(5'd5); tick();
        idle();
        #1;
        check_eq("t3_pending_kept", 41'(pending), 41'(3));
        check_eq("t3_busy5", 41'(busy_vec[5]), 41'(1));
        // protocol violation: issue into a full counter saturates
        issue(5'd5); tick();
        idle();
        #1; check_eq("t3_saturate", 41'(pending), 41'(3));
        wv = 1; wrd = 5; tick(); tick(); tick();
        idle();
        #1; check_eq("t3_drained", 41'(pending), 41'(0));

        // 4: issue and release of r7 in the same cycle
        issue(5'd7); tick();
        issue(5'd7); wv = 1; wrd = 7; tick();
        idle();
        #1;
        check_eq("t4_busy7", 41'(busy_vec[7]), 41'(1));
        check_eq("t4_pending1", 41'(pending), 41'(1));
        wv = 1; wrd = 7; tick();
        idle();

        // 5: release of an idle register sets the sticky error
        #1; check_eq("t5_err_before", 41'(sb_error), 41'(0));
        wv = 1; wrd = 9; tick();
        idle();
        #1; check_eq("t5_err_set", 41'(sb_error), 41'(1));
        fl = 1; tick();
        idle();
        #1; check_eq("t5_err_sticky", 41'(sb_error), 41'(1));

        // 6: flush wins over a simultaneous issue
        issue(5'd3); tick();
        issue(5'd4); tick();
        issue(5'd6); tick();
        idle();
        #1; check_eq("t6_pending3", 41'(pending), 41'(3));
        issue(5'd8); fl = 1; tick();
        idle(); ur1 = 1; rs1 = 3; ur2 = 1; rs2 = 8;
        #1;
        check_eq("t6_busy_clear", 41'(busy_vec), 41'(0));
        check_eq("t6_pending0", 41'(pending), 41'(0));
        check_eq("t6_stall0", 41'(stall), 41'(0));

        // random phase, never issuing while the model says stall
        for (int n = 0; n < 400; n++) begin
            idle();
            ur1 = 1'($urandom_range(0, 1)); rs1 = 5'($urandom_range(0, 7));
            ur2 = 1'($urandom_range(0, 1)); rs2 = 5'($urandom_range(0, 7));
            qw  = 1'($urandom_range(0, 1)); qrd = 5'($urandom_range(0, 7));
            wv  = ($urandom_range(0, 2) == 0); wrd = 5'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 60) == 0);
            if (!m_stall() && $urandom_range(0, 1) == 1) begin
                iv = 1; iw = 1'($urandom_range(0, 3) != 0); ird = 5'($urandom_range(0, 7));
            end
            tick();
        end

        // reset mid-operation overrides everything else
        idle(); issue(5'd12); tick();
        issue(5'd13); wv = 1; wrd = 14; rst = 1; tick();
        idle();
        #1;
        check_eq("t7_reset_pending", 41'(pending), 41'(0));
        check_eq("t7_reset_busy", 41'(busy_vec), 41'(0));
        check_eq("t7_reset_err", 41'(sb_error), 41'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
